// File: rtl/cpu_pkg.sv
// Shared CPU-front-end types: datapath widths, the NOP encoding and the fetch FSM states.
// Used by the fetch unit, the IF/ID buffer and decode.
package cpu_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 16;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry {pc, inst} holding register; keeps an instruction returned while decode is stalled.
module fetch_skid_reg
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o
);

    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            pc_q   <= '0;
            inst_q <= NOP_INST;
        end else if (load_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID buffer: PC ownership, stall skid and branch redirect.
// Define FETCH_PERF_EN to add the saturating perf_bubble_cnt output.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_INC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [PC_W-1:0]   pc_buff_in,
    output logic [INST_W-1:0] inst_buff_in,
    output logic              nop_in,
    output logic              flush
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_bubble_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [PC_W-1:0]   pc_next;
    logic              skid_load, skid_clear;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    assign pc_next   = fetch_pc_q + PC_W'(PC_INC);
    assign imem_addr = fetch_pc_q;
    assign flush     = br_taken;

    fetch_skid_reg u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (fetch_pc_q),
        .inst_i  (imem_rdata),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        imem_req     = 1'b0;
        nop_in       = 1'b1;
        pc_buff_in   = '0;
        inst_buff_in = NOP_INST;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        // Reset outranks everything, so no request or delivery escapes in the reset cycle.
        if (!rst) begin
            unique case (state_q)
                IDLE: state_d = REQ;

                REQ: begin
                    imem_req = 1'b1;
                    if (br_taken) begin
                        if (imem_ready) begin
                            fetch_pc_d = br_target;
                        end else begin
                            pend_pc_d = br_target;
                            state_d   = DRAIN;
                        end
                    end else if (imem_ready) begin
                        fetch_pc_d = pc_next;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            nop_in       = 1'b0;
                            pc_buff_in   = fetch_pc_q;
                            inst_buff_in = imem_rdata;
                        end
                    end
                end

                HOLD: begin
                    if (br_taken) begin
                        skid_clear = 1'b1;
                        fetch_pc_d = br_target;
                        state_d    = REQ;
                    end else if (!stall) begin
                        nop_in       = 1'b0;
                        pc_buff_in   = skid_pc;
                        inst_buff_in = skid_inst;
                        skid_clear   = 1'b1;
                        state_d      = REQ;
                    end
                end

                DRAIN: begin
                    // Keep the old address until memory answers, then discard that answer.
                    imem_req = 1'b1;
                    if (br_taken) begin
                        pend_pc_d = br_target;
                    end
                    if (imem_ready) begin
                        fetch_pc_d = br_taken ? br_target : pend_pc_q;
                        state_d    = REQ;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (nop_in && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, stall skid, branch redirects, reset, wrap.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ready;
    logic [INST_W-1:0] imem_rdata;
    logic [PC_W-1:0]   pc_buff_in;
    logic [INST_W-1:0] inst_buff_in;
    logic              nop_in;
    logic              flush;
`ifdef FETCH_PERF_EN
    logic [15:0]       perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Instruction memory contents: upper byte tag, lower byte mirrors the address.
    assign imem_rdata = {8'hA5, imem_addr[7:0]};

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_buff_in   (pc_buff_in),
        .inst_buff_in (inst_buff_in),
        .nop_in       (nop_in),
        .flush        (flush)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge, checks happen 2 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        #2;
        chk({tag, ".nop"}, 32'(nop_in), 32'd1);
        chk({tag, ".inst"}, 32'(inst_buff_in), 32'(NOP_INST));
    endtask

    task automatic chk_deliver(input string tag, input logic [15:0] pc, input logic [15:0] inst);
        #2;
        chk({tag, ".nop"}, 32'(nop_in), 32'd0);
        chk({tag, ".pc"}, 32'(pc_buff_in), 32'(pc));
        chk({tag, ".inst"}, 32'(inst_buff_in), 32'(inst));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; imem_ready = 1'b1;
        #1;
        // Reset: two cycles
        #2;
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.pc", 32'(pc_buff_in), 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        step();
        step();
        rst = 1'b0;
        chk_bubble("idle");
        chk("idle.req", 32'(imem_req), 32'd0);

        // Sequential fetch at 0,2,4 with memory always ready
        step();
        #2;
        chk("f0.req", 32'(imem_req), 32'd1);
        chk("f0.addr", 32'(imem_addr), 32'h0000);
        chk_deliver("f0", 16'h0000, 16'hA500);
        step();
        chk_deliver("f2", 16'h0002, 16'hA502);
        step();

        // Stall during the fetch of PC 4: captured in skid, held 3 cycles total
        stall = 1'b1;
        #2;
        chk("st.addr", 32'(imem_addr), 32'h0004);
        chk_bubble("st0");
        step();
        #2;
        chk("hold.req", 32'(imem_req), 32'd0);
        chk_bubble("hold1");
        step();
        chk_bubble("hold2");
        step();
        stall = 1'b0;
        chk_deliver("skid", 16'h0004, 16'hA504);
        chk("skid.req", 32'(imem_req), 32'd0);
        step();
        #2;
        chk("f6.addr", 32'(imem_addr), 32'h0006);
        chk_deliver("f6", 16'h0006, 16'hA506);
        step();

        // Branch to 0x0040 while memory answers: data dropped
        br_taken = 1'b1; br_target = 16'h0040;
        #2;
        chk("br1.flush", 32'(flush), 32'd1);
        chk("br1.addr", 32'(imem_addr), 32'h0008);
        chk_bubble("br1");
        step();
        br_taken = 1'b0;
        #2;
        chk("br1.flush_off", 32'(flush), 32'd0);
        chk("tgt40.addr", 32'(imem_addr), 32'h0040);
        chk_deliver("tgt40", 16'h0040, 16'hA540);
        step();

        // Branch to 0x0080 with memory busy, then 0x00A0 while draining
        imem_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0080;
        #2;
        chk("br2.flush", 32'(flush), 32'd1);
        chk_bubble("br2");
        step();
        br_taken = 1'b0;
        #2;
        chk("dr1.req", 32'(imem_req), 32'd1);
        chk("dr1.addr", 32'(imem_addr), 32'h0042);
        chk_bubble("dr1");
        step();
        br_taken = 1'b1; br_target = 16'h00A0;
        #2;
        chk("dr2.flush", 32'(flush), 32'd1);
        chk("dr2.addr", 32'(imem_addr), 32'h0042);
        chk_bubble("dr2");
        step();
        br_taken = 1'b0; imem_ready = 1'b1;
        #2;
        chk("dr3.addr", 32'(imem_addr), 32'h0042);
        chk_bubble("dr3");
        step();
        #2;
        chk("tgtA0.addr", 32'(imem_addr), 32'h00A0);
        chk_deliver("tgtA0", 16'h00A0, 16'hA5A0);
        step();

        // Reset while in HOLD
        stall = 1'b1;
        step();
        rst = 1'b1;
        #2;
        chk("rsth.req", 32'(imem_req), 32'd0);
        chk_bubble("rsth");
        step();
        rst = 1'b0; stall = 1'b0;
        #2;
        chk("rsth.idle_req", 32'(imem_req), 32'd0);
        chk("rsth.idle_pc", 32'(pc_buff_in), 32'd0);
        chk_bubble("rsth.idle");
        step();
        #2;
        chk("rsth.addr", 32'(imem_addr), 32'h0000);
        chk_deliver("rsth.f0", 16'h0000, 16'hA500);
        step();

        // Reset while in DRAIN
        imem_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0080;
        step();
        br_taken = 1'b0; rst = 1'b1;
        #2;
        chk("rstd.req", 32'(imem_req), 32'd0);
        step();
        rst = 1'b0; imem_ready = 1'b1;
        #2;
        chk("rstd.idle_req", 32'(imem_req), 32'd0);
        chk_bubble("rstd.idle");
        step();
        #2;
        chk("rstd.addr", 32'(imem_addr), 32'h0000);
        chk_deliver("rstd.f0", 16'h0000, 16'hA500);

        // PC wrap: redirect to 0xFFFE, next fetch at 0x0000
        br_taken = 1'b1; br_target = 16'hFFFE;
        step();
        br_taken = 1'b0;
        #2;
        chk("wrap.addr", 32'(imem_addr), 32'hFFFE);
        chk_deliver("wrap.fe", 16'hFFFE, 16'hA5FE);
        step();
        #2;
        chk("wrap.addr0", 32'(imem_addr), 32'h0000);
        chk_deliver("wrap.f0", 16'h0000, 16'hA500);

`ifdef FETCH_PERF_EN
        // Bubble counter: IDLE cycle plus four unanswered REQ cycles
        rst = 1'b1;
        step();
        rst = 1'b0; imem_ready = 1'b0;
        #2;
        chk("perf.rst", 32'(perf_bubble_cnt), 32'd0);
        for (int i = 0; i < 5; i++) step();
        #2;
        chk("perf.five", 32'(perf_bubble_cnt), 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
